// File: rtl/gerencia_destruicao_asteroides_if.sv
// rtl/gerencia_destruicao_asteroides_if.sv - destruction capture and valid-memory write bundle
interface gerencia_destruicao_asteroides_if #(
    parameter int ASTEROIDE_ADDR_W = 4,
    parameter int TIRO_ADDR_W      = 4
);
    logic                        asteroide_destruido;
    logic [ASTEROIDE_ADDR_W-1:0] indice_asteroide;
    logic [TIRO_ADDR_W-1:0]      indice_tiro;
    logic                        s_fim_comparacao;
    logic                        we_asteroide;
    logic [ASTEROIDE_ADDR_W-1:0] addr_asteroide;
    logic                        we_tiro;
    logic [TIRO_ADDR_W-1:0]      addr_tiro;
    logic                        dado_invalido;
    logic                        fim_destruicao;

    modport master (
        output asteroide_destruido, indice_asteroide, indice_tiro, s_fim_comparacao,
        input  we_asteroide, addr_asteroide, we_tiro, addr_tiro, dado_invalido, fim_destruicao
    );

    modport slave (
        input  asteroide_destruido, indice_asteroide, indice_tiro, s_fim_comparacao,
        output we_asteroide, addr_asteroide, we_tiro, addr_tiro, dado_invalido, fim_destruicao
    );
endinterface

// File: rtl/gerencia_destruicao_asteroides.sv
// rtl/gerencia_destruicao_asteroides.sv - queues asteroid destructions and applies them to memories and score
// Optional: define PONTUACAO_SATURA_EN to clamp the score instead of wrapping.
module gerencia_destruicao_asteroides #(
    parameter int ASTEROIDE_ADDR_W = 4,
    parameter int TIRO_ADDR_W      = 4,
    parameter int PONTUACAO_W      = 10,
    parameter int PONTOS           = 1,
    parameter int FILA_PROF_LOG2   = 2
) (
    input  logic                   clock,
    input  logic                   reset,
    gerencia_destruicao_asteroides_if.slave bus,
    input  logic                   zera_pontuacao,
    output logic [PONTUACAO_W-1:0] pontuacao,
    output logic                   ocupado,
    output logic                   db_overflow,
    output logic [4:0]             db_estado
);
    localparam int FILA_PROF = 1 << FILA_PROF_LOG2;
    localparam int ENTRADA_W = ASTEROIDE_ADDR_W + TIRO_ADDR_W;

    localparam logic [4:0] S_INICIAL         = 5'd0;
    localparam logic [4:0] S_ESPERA          = 5'd1;
    localparam logic [4:0] S_LE_FILA         = 5'd2;
    localparam logic [4:0] S_APAGA_ASTEROIDE = 5'd3;
    localparam logic [4:0] S_APAGA_TIRO      = 5'd4;
    localparam logic [4:0] S_PONTUA          = 5'd5;
    localparam logic [4:0] S_FIM             = 5'd6;

    logic [4:0]                  estado_q, estado_d;
    logic [ENTRADA_W-1:0]        fila_q [FILA_PROF];
    logic [FILA_PROF_LOG2-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [FILA_PROF_LOG2:0]     cnt_q, cnt_d;
    logic                        fim_pendente_q, fim_pendente_d;
    logic                        overflow_q, overflow_d;
    logic [PONTUACAO_W-1:0]      pontuacao_q, pontuacao_d, pontuacao_inc;
    logic [ASTEROIDE_ADDR_W-1:0] addr_asteroide_q, addr_asteroide_d;
    logic [TIRO_ADDR_W-1:0]      addr_tiro_q, addr_tiro_d;
    logic                        we_asteroide_q, we_asteroide_d;
    logic                        we_tiro_q, we_tiro_d;
    logic                        fim_q, fim_d;
    logic                        ocupado_q, ocupado_d;
    logic                        cheia, vazia, push, pop;
    logic [ENTRADA_W-1:0]        cabeca;

`ifdef PONTUACAO_SATURA_EN
    logic [PONTUACAO_W:0] soma;
    always_comb begin
        soma          = {1'b0, pontuacao_q} + (PONTUACAO_W+1)'(PONTOS);
        pontuacao_inc = soma[PONTUACAO_W] ? {PONTUACAO_W{1'b1}} : soma[PONTUACAO_W-1:0];
    end
`else
    always_comb begin
        pontuacao_inc = pontuacao_q + PONTUACAO_W'(PONTOS);
    end
`endif

    always_comb begin
        cheia  = (cnt_q == (FILA_PROF_LOG2+1)'(FILA_PROF));
        vazia  = (cnt_q == '0);
        // A push into a full queue is dropped even if a pop happens that same cycle.
        push   = bus.asteroide_destruido && !cheia;
        pop    = (estado_q == S_LE_FILA);
        cabeca = fila_q[rd_ptr_q];

        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        cnt_d    = cnt_q;
        if (push && !pop)
            cnt_d = cnt_q + 1'b1;
        else if (pop && !push)
            cnt_d = cnt_q - 1'b1;
        overflow_d = overflow_q || (bus.asteroide_destruido && cheia);

        estado_d = estado_q;
        case (estado_q)
            S_INICIAL:         estado_d = S_ESPERA;
            S_ESPERA: begin
                if (!vazia)
                    estado_d = S_LE_FILA;
                else if (fim_pendente_q)
                    estado_d = S_FIM;
            end
            S_LE_FILA:         estado_d = S_APAGA_ASTEROIDE;
            S_APAGA_ASTEROIDE: estado_d = S_APAGA_TIRO;
            S_APAGA_TIRO:      estado_d = S_PONTUA;
            S_PONTUA:          estado_d = S_ESPERA;
            S_FIM:             estado_d = S_ESPERA;
            default:           estado_d = S_INICIAL;
        endcase

        // A new end-of-pass arriving as FIM is entered is kept for the next pass.
        fim_pendente_d = (fim_pendente_q && (estado_d != S_FIM)) || bus.s_fim_comparacao;

        addr_asteroide_d = pop ? cabeca[ENTRADA_W-1:TIRO_ADDR_W] : addr_asteroide_q;
        addr_tiro_d      = pop ? cabeca[TIRO_ADDR_W-1:0]         : addr_tiro_q;
        we_asteroide_d   = (estado_d == S_APAGA_ASTEROIDE);
        we_tiro_d        = (estado_d == S_APAGA_TIRO);
        fim_d            = (estado_d == S_FIM);
        ocupado_d        = (cnt_d != '0) || !((estado_d == S_INICIAL) || (estado_d == S_ESPERA));

        pontuacao_d = pontuacao_q;
        if (zera_pontuacao)
            pontuacao_d = '0;
        else if (estado_q == S_PONTUA)
            pontuacao_d = pontuacao_inc;
    end

    always_ff @(posedge clock) begin
        if (push)
            fila_q[wr_ptr_q] <= {bus.indice_asteroide, bus.indice_tiro};
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            estado_q         <= S_INICIAL;
            wr_ptr_q         <= '0;
            rd_ptr_q         <= '0;
            cnt_q            <= '0;
            fim_pendente_q   <= 1'b0;
            overflow_q       <= 1'b0;
            pontuacao_q      <= '0;
            addr_asteroide_q <= '0;
            addr_tiro_q      <= '0;
            we_asteroide_q   <= 1'b0;
            we_tiro_q        <= 1'b0;
            fim_q            <= 1'b0;
            ocupado_q        <= 1'b0;
        end else begin
            estado_q         <= estado_d;
            wr_ptr_q         <= wr_ptr_d;
            rd_ptr_q         <= rd_ptr_d;
            cnt_q            <= cnt_d;
            fim_pendente_q   <= fim_pendente_d;
            overflow_q       <= overflow_d;
            pontuacao_q      <= pontuacao_d;
            addr_asteroide_q <= addr_asteroide_d;
            addr_tiro_q      <= addr_tiro_d;
            we_asteroide_q   <= we_asteroide_d;
            we_tiro_q        <= we_tiro_d;
            fim_q            <= fim_d;
            ocupado_q        <= ocupado_d;
        end
    end

    assign bus.we_asteroide   = we_asteroide_q;
    assign bus.addr_asteroide = addr_asteroide_q;
    assign bus.we_tiro        = we_tiro_q;
    assign bus.addr_tiro      = addr_tiro_q;
    assign bus.dado_invalido  = 1'b0;
    assign bus.fim_destruicao = fim_q;
    assign pontuacao          = pontuacao_q;
    assign ocupado            = ocupado_q;
    assign db_overflow        = overflow_q;
    assign db_estado          = estado_q;
endmodule

// File: tb/tb_gerencia_destruicao_asteroides.sv
// tb/tb_gerencia_destruicao_asteroides.sv - randomized bench with a queue-based reference model
module tb_gerencia_destruicao_asteroides;
    localparam int AW = 4, TW = 4, PW = 10, PTS = 1, FL = 2, DEPTH = 4;

    logic          clock = 1'b0;
    logic          reset;
    logic          zera_pontuacao;
    logic [PW-1:0] pontuacao;
    logic          ocupado, db_overflow;
    logic [4:0]    db_estado;

    always #5 clock = ~clock;

    gerencia_destruicao_asteroides_if #(.ASTEROIDE_ADDR_W(AW), .TIRO_ADDR_W(TW)) bus ();

    gerencia_destruicao_asteroides #(
        .ASTEROIDE_ADDR_W(AW), .TIRO_ADDR_W(TW), .PONTUACAO_W(PW),
        .PONTOS(PTS), .FILA_PROF_LOG2(FL)
    ) dut (
        .clock(clock), .reset(reset), .bus(bus), .zera_pontuacao(zera_pontuacao),
        .pontuacao(pontuacao), .ocupado(ocupado), .db_overflow(db_overflow), .db_estado(db_estado)
    );

    int n_total = 0, n_pass = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", nm, got, exp, $time);
    endtask

    // Reference model: phase 0 reset, 1 idle, 2 read, 3 clear asteroid, 4 clear shot, 5 score, 6 done.
    int  q_a[$], q_t[$];
    int  m_ph = 0, m_ca = 0, m_ct = 0, m_score = 0;
    bit  m_pend = 0, m_ovf = 0, model_ok = 0;

    always @(posedge clock) begin : modelo
        int n_antes, prox;
        if (reset) begin
            q_a.delete(); q_t.delete();
            m_ph = 0; m_pend = 0; m_ovf = 0; m_score = 0; m_ca = 0; m_ct = 0;
            model_ok = 1;
        end else begin
            n_antes = q_a.size();
            prox = 1;
            case (m_ph)
                1: prox = (n_antes > 0) ? 2 : (m_pend ? 6 : 1);
                2: begin prox = 3; m_ca = q_a.pop_front(); m_ct = q_t.pop_front(); end
                3: prox = 4;
                4: prox = 5;
                default: prox = 1;
            endcase
            if (bus.asteroide_destruido) begin
                if (n_antes == DEPTH) m_ovf = 1;
                else begin q_a.push_back(int'(bus.indice_asteroide)); q_t.push_back(int'(bus.indice_tiro)); end
            end
            if (prox == 6) m_pend = 0;
            if (bus.s_fim_comparacao) m_pend = 1;
            if (m_ph == 5) begin
`ifdef PONTUACAO_SATURA_EN
                m_score = (m_score + PTS > (1 << PW) - 1) ? (1 << PW) - 1 : m_score + PTS;
`else
                m_score = (m_score + PTS) % (1 << PW);
`endif
            end
            if (zera_pontuacao) m_score = 0;
            m_ph = prox;
        end
    end

    always @(negedge clock) begin
        if (model_ok) begin
            chk("db_estado", db_estado, m_ph);
            chk("we_asteroide", bus.we_asteroide, m_ph == 3);
            if (m_ph == 3) chk("addr_asteroide", bus.addr_asteroide, m_ca);
            chk("we_tiro", bus.we_tiro, m_ph == 4);
            if (m_ph == 4) chk("addr_tiro", bus.addr_tiro, m_ct);
            chk("fim_destruicao", bus.fim_destruicao, m_ph == 6);
            chk("pontuacao", pontuacao, m_score);
            chk("ocupado", ocupado, (q_a.size() != 0) || (m_ph > 1));
            chk("db_overflow", db_overflow, m_ovf);
            chk("dado_invalido", bus.dado_invalido, 0);
        end
    end

    int log_a[$], log_t[$];
    int fim_cnt = 0;
    always @(negedge clock) begin
        if (bus.we_asteroide) log_a.push_back(int'(bus.addr_asteroide));
        if (bus.we_tiro) log_t.push_back(int'(bus.addr_tiro));
        if (bus.fim_destruicao) fim_cnt++;
    end

    task automatic cyc(input logic d, input int a, input int t, input logic f, input logic z, input logic r);
        @(negedge clock);
        bus.asteroide_destruido = d;
        bus.indice_asteroide    = AW'(a);
        bus.indice_tiro         = TW'(t);
        bus.s_fim_comparacao    = f;
        zera_pontuacao          = z;
        reset                   = r;
    endtask

    task automatic esperar_ocioso(input string nm);
        int n = 0;
        while (!(q_a.size() == 0 && m_ph == 1 && !m_pend) && n < 300) begin
            cyc(0, 0, 0, 0, 0, 0);
            n++;
        end
        chk({nm, "_timeout"}, n < 300, 1);
        cyc(0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        int strobes, achou;
        bus.asteroide_destruido = 0; bus.indice_asteroide = '0; bus.indice_tiro = '0;
        bus.s_fim_comparacao = 0; zera_pontuacao = 0; reset = 1;

        repeat (5) cyc(0, 0, 0, 0, 0, 1);
        chk("rst_estado", db_estado, 0);
        chk("rst_pontuacao", pontuacao, 0);
        chk("rst_ocupado", ocupado, 0);
        chk("rst_we", {bus.we_asteroide, bus.we_tiro, bus.fim_destruicao, db_overflow}, 0);
        cyc(0, 0, 0, 0, 0, 0);
        chk("rst_estado_hold", db_estado, 0);
        cyc(0, 0, 0, 0, 0, 0);
        chk("rst_estado_espera", db_estado, 1);

        cyc(1, 3, 7, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0); chk("s1_espera", db_estado, 1);
        cyc(0, 0, 0, 0, 0, 0); chk("s1_le_fila", db_estado, 2);
        cyc(0, 0, 0, 0, 0, 0); chk("s1_we_ast", {bus.we_asteroide, 4'(bus.addr_asteroide)}, {1'b1, 4'd3});
        cyc(0, 0, 0, 0, 0, 0); chk("s1_we_tiro", {bus.we_tiro, 4'(bus.addr_tiro)}, {1'b1, 4'd7});
        cyc(0, 0, 0, 0, 0, 0); chk("s1_pont_antes", pontuacao, 0);
        cyc(0, 0, 0, 0, 0, 0); chk("s1_pont", pontuacao, 1);

        log_a.delete(); log_t.delete(); fim_cnt = 0;
        cyc(1, 2, 1, 0, 0, 0);
        cyc(1, 5, 4, 0, 0, 0);
        cyc(1, 9, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 0, 0);
        esperar_ocioso("s3");
        chk("s3_pont", pontuacao, 4);
        chk("s3_fim_cnt", fim_cnt, 1);
        chk("s3_n_writes", log_a.size() * 16 + log_t.size(), 3 * 16 + 3);
        if (log_a.size() == 3 && log_t.size() == 3) begin
            chk("s3_ordem_ast", log_a[0] * 256 + log_a[1] * 16 + log_a[2], 2 * 256 + 5 * 16 + 9);
            chk("s3_ordem_tiro", log_t[0] * 256 + log_t[1] * 16 + log_t[2], 1 * 256 + 4 * 16 + 0);
        end

        cyc(0, 0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 0, 0);
        chk("zera", pontuacao, 0);

        for (int i = 0; i < 5; i++) cyc(1, i, i + 8, 0, 0, 0);
        esperar_ocioso("b5");
        chk("b5_overflow", db_overflow, 0);
        chk("b5_pont", pontuacao, 5);

        for (int i = 0; i < 6; i++) cyc(1, i + 6, i, 0, 0, 0);
        esperar_ocioso("b6");
        chk("b6_overflow", db_overflow, 1);
        chk("b6_pont", pontuacao, 10);

        cyc(1, 1, 1, 0, 0, 0);
        cyc(1, 2, 2, 0, 0, 0);
        cyc(1, 3, 3, 0, 0, 0);
        achou = 0;
        for (int i = 0; i < 20 && achou == 0; i++) begin
            cyc(0, 0, 0, 0, 0, 0);
            if (bus.we_tiro) achou = 1;
        end
        chk("rm_achou_tiro", achou, 1);
        cyc(0, 0, 0, 0, 0, 1);
        strobes = 0;
        for (int i = 0; i < 12; i++) begin
            cyc(0, 0, 0, 0, 0, 0);
            strobes += int'(bus.we_asteroide) + int'(bus.we_tiro);
        end
        chk("rm_strobes", strobes, 0);
        chk("rm_pont", pontuacao, 0);
        chk("rm_ocupado", ocupado, 0);
        chk("rm_overflow", db_overflow, 0);

        for (int i = 0; i < 1030; i++) begin
            cyc(1, i % 16, (i * 3) % 16, 0, 0, 0);
            repeat (5) cyc(0, 0, 0, 0, 0, 0);
        end
        esperar_ocioso("wrap");
`ifdef PONTUACAO_SATURA_EN
        chk("wrap_pont", pontuacao, 1023);
`else
        chk("wrap_pont", pontuacao, 6);
`endif

        for (int i = 0; i < 3000; i++) begin
            cyc($urandom_range(0, 3) == 0, $urandom_range(0, 15), $urandom_range(0, 15),
                $urandom_range(0, 19) == 0, $urandom_range(0, 99) == 0, $urandom_range(0, 499) == 0);
        end
        cyc(0, 0, 0, 1, 0, 0);
        esperar_ocioso("rand");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
